// File: rtl/stop_watch_dp.sv
// rtl/stop_watch_dp.sv - stopwatch datapath: 10 ms time base and hh:mm:ss.cc counters
module stop_watch_dp #(
  parameter int P_TICK_DIV = 1_000_000,
  parameter int P_DIV_W    = 20
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRun_Stop,
  input  logic       iClear,
  output logic [6:0] oMsec,
  output logic [5:0] oSec,
  output logic [5:0] oMin,
  output logic [4:0] oHour,
  output logic       oTick,
  output logic       oRollover
);

  // Last divider value before the 10 ms time base wraps.
  localparam logic [P_DIV_W-1:0] L_DIV_LAST = P_DIV_W'(P_TICK_DIV - 1);

  logic [P_DIV_W-1:0] r_div;
  logic [6:0]         r_msec;
  logic [5:0]         r_sec;
  logic [5:0]         r_min;
  logic [4:0]         r_hour;
  logic               r_tick;
  logic               r_rollover;

  logic               w_div_last;
  logic               w_msec_carry;
  logic               w_sec_carry;
  logic               w_min_carry;
  logic               w_hour_carry;
  logic [6:0]         w_msec_nxt;
  logic [5:0]         w_sec_nxt;
  logic [5:0]         w_min_nxt;
  logic [4:0]         w_hour_nxt;

  // >= rather than == so an out-of-range divider still wraps instead of
  // running away through the whole counter range.
  assign w_div_last = (r_div >= L_DIV_LAST);

  // Cascade: each field wraps to 0 with carry at (or beyond) its top value,
  // so a forced illegal value recovers on the next tick.
  assign w_msec_carry = (r_msec >= 7'd99);
  assign w_sec_carry  = w_msec_carry && (r_sec  >= 6'd59);
  assign w_min_carry  = w_sec_carry  && (r_min  >= 6'd59);
  assign w_hour_carry = w_min_carry  && (r_hour >= 5'd23);

  assign w_msec_nxt = w_msec_carry ? 7'd0 : r_msec + 7'd1;
  assign w_sec_nxt  = !w_msec_carry ? r_sec  : ((r_sec  >= 6'd59) ? 6'd0 : r_sec  + 6'd1);
  assign w_min_nxt  = !w_sec_carry  ? r_min  : ((r_min  >= 6'd59) ? 6'd0 : r_min  + 6'd1);
  assign w_hour_nxt = !w_min_carry  ? r_hour : ((r_hour >= 5'd23) ? 5'd0 : r_hour + 5'd1);

  // Divider, time fields and event pulses; reset beats clear beats run.
  always_ff @(posedge iClk) begin
    if (iRst || iClear) begin
      r_div      <= '0;
      r_msec     <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_tick     <= 1'b0;
      r_rollover <= 1'b0;
    end else if (iRun_Stop) begin
      if (w_div_last) begin
        r_div      <= '0;
        r_msec     <= w_msec_nxt;
        r_sec      <= w_sec_nxt;
        r_min      <= w_min_nxt;
        r_hour     <= w_hour_nxt;
        r_tick     <= 1'b1;
        r_rollover <= w_hour_carry;
      end else begin
        r_div      <= r_div + 1'b1;
        r_tick     <= 1'b0;
        r_rollover <= 1'b0;
      end
    end else begin
      // Stopped: divider keeps its partial progress so resume loses no time.
      r_tick     <= 1'b0;
      r_rollover <= 1'b0;
    end
  end

  assign oMsec     = r_msec;
  assign oSec      = r_sec;
  assign oMin      = r_min;
  assign oHour     = r_hour;
  assign oTick     = r_tick;
  assign oRollover = r_rollover;

endmodule

// File: tb/tb_stop_watch_dp.sv
// tb/tb_stop_watch_dp.sv - scoreboard bench for stop_watch_dp
module tb_stop_watch_dp;

  localparam int DIV = 4;
  localparam int DW  = 4;
  localparam int DAY = 24 * 60 * 60 * 100;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iRun_Stop = 1'b0;
  logic       iClear = 1'b0;
  logic [6:0] oMsec;
  logic [5:0] oSec;
  logic [5:0] oMin;
  logic [4:0] oHour;
  logic       oTick;
  logic       oRollover;

  stop_watch_dp #(
    .P_TICK_DIV (DIV),
    .P_DIV_W    (DW)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iRun_Stop (iRun_Stop),
    .iClear    (iClear),
    .oMsec     (oMsec),
    .oSec      (oSec),
    .oMin      (oMin),
    .oHour     (oHour),
    .oTick     (oTick),
    .oRollover (oRollover)
  );

  always #5 iClk = ~iClk;

  int checks   = 0;
  int failures = 0;

  // Reference model: elapsed centiseconds of the day plus divider phase.
  int m_cs  = 0;
  int m_div = 0;

  logic [25:0] sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] pack_exp(input bit t, input bit r, input int cs);
    return {t, r, 5'(cs / 360000), 6'((cs / 6000) % 60), 6'((cs / 100) % 60), 7'(cs % 100)};
  endfunction

  // Drive one cycle, predict the post-edge outputs, then compare them.
  task automatic step(input bit rst, input bit run, input bit clr);
    bit          t;
    bit          r;
    logic [25:0] e;
    logic [25:0] got;
    t = 1'b0;
    r = 1'b0;
    iRst      = rst;
    iRun_Stop = run;
    iClear    = clr;
    if (rst || clr) begin
      m_div = 0;
      m_cs  = 0;
    end else if (run) begin
      if (m_div == DIV - 1) begin
        m_div = 0;
        t     = 1'b1;
        m_cs  = m_cs + 1;
        if (m_cs == DAY) begin
          m_cs = 0;
          r    = 1'b1;
        end
      end else begin
        m_div = m_div + 1;
      end
    end
    sb_q.push_back(pack_exp(t, r, m_cs));
    @(posedge iClk);
    #1;
    e   = sb_q.pop_front();
    got = {oTick, oRollover, oHour, oMin, oSec, oMsec};
    check_val("sb", 32'(got), 32'(e));
  endtask

  // Run until oTick shows; n is the number of running cycles taken (bounded).
  task automatic run_until_tick(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end while (!oTick && n < 20);
  endtask

  int         n;
  logic [6:0] snap_msec;

  initial begin
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_val("rst_msec", 32'(oMsec), 0);
    check_val("rst_sec", 32'(oSec), 0);
    check_val("rst_min", 32'(oMin), 0);
    check_val("rst_hour", 32'(oHour), 0);
    check_val("rst_tick", 32'(oTick), 0);
    check_val("rst_roll", 32'(oRollover), 0);

    run_until_tick(n);
    check_val("first_tick_lat", n, 4);
    check_val("first_msec", 32'(oMsec), 1);
    run_until_tick(n);
    check_val("tick_period", n, 4);
    for (int i = 2; i < 100; i++) run_until_tick(n);
    check_val("100t_sec", 32'(oSec), 1);
    check_val("100t_msec", 32'(oMsec), 0);

    // Preload 00:00:59.99 with the divider one cycle from wrapping.
    step(1'b0, 1'b0, 1'b0);
    force dut.r_hour = 5'd0;
    force dut.r_min  = 6'd0;
    force dut.r_sec  = 6'd59;
    force dut.r_msec = 7'd99;
    force dut.r_div  = 4'd3;
    #1;
    release dut.r_hour;
    release dut.r_min;
    release dut.r_sec;
    release dut.r_msec;
    release dut.r_div;
    m_cs  = 5999;
    m_div = 3;
    step(1'b0, 1'b1, 1'b0);
    check_val("min_carry_sec", 32'(oSec), 0);
    check_val("min_carry_min", 32'(oMin), 1);
    check_val("min_carry_msec", 32'(oMsec), 0);
    check_val("min_carry_tick", 32'(oTick), 1);
    check_val("min_carry_roll", 32'(oRollover), 0);

    // Preload 23:59:59.99 and cross midnight.
    step(1'b0, 1'b0, 1'b0);
    force dut.r_hour = 5'd23;
    force dut.r_min  = 6'd59;
    force dut.r_sec  = 6'd59;
    force dut.r_msec = 7'd99;
    force dut.r_div  = 4'd3;
    #1;
    release dut.r_hour;
    release dut.r_min;
    release dut.r_sec;
    release dut.r_msec;
    release dut.r_div;
    m_cs  = DAY - 1;
    m_div = 3;
    step(1'b0, 1'b1, 1'b0);
    check_val("wrap_fields", 32'({oHour, oMin, oSec, oMsec}), 0);
    check_val("wrap_roll", 32'(oRollover), 1);
    check_val("wrap_tick", 32'(oTick), 1);
    step(1'b0, 1'b1, 1'b0);
    check_val("wrap_roll_1cyc", 32'(oRollover), 0);

    // Stop two cycles into a tick, hold, then resume.
    run_until_tick(n);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    snap_msec = oMsec;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check_val("hold_msec", 32'(oMsec), 32'(snap_msec));
    run_until_tick(n);
    check_val("resume_lat", n, 2);

    // Clear aligned with a tick at 00:01:23.45.
    step(1'b0, 1'b0, 1'b0);
    force dut.r_hour = 5'd0;
    force dut.r_min  = 6'd1;
    force dut.r_sec  = 6'd23;
    force dut.r_msec = 7'd45;
    force dut.r_div  = 4'd3;
    #1;
    release dut.r_hour;
    release dut.r_min;
    release dut.r_sec;
    release dut.r_msec;
    release dut.r_div;
    m_cs  = 6000 + 2300 + 45;
    m_div = 3;
    step(1'b0, 1'b1, 1'b1);
    check_val("clr_fields", 32'({oHour, oMin, oSec, oMsec}), 0);
    check_val("clr_tick", 32'(oTick), 0);
    run_until_tick(n);
    check_val("clr_restart_lat", n, 4);

    // Reset mid-count while running.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_val("rst_mid_fields", 32'({oHour, oMin, oSec, oMsec}), 0);
    check_val("rst_mid_tick", 32'(oTick), 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_val("rst_hold_msec", 32'(oMsec), 0);
    run_until_tick(n);
    check_val("rst_restart_lat", n, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
